// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver: 2-flop input synchronizer, mid-bit sampling, registered 1-cycle strobes.
// Strobe lands ~CLKS_PER_BIT*9.5+3 cycles after the start edge; no backpressure, an unread byte is overwritten.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_data_rdy,
    output logic       rx_frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state, stateNxt;
    logic [CNT_W-1:0] cnt, cntNxt;
    logic [2:0]       idx, idxNxt;
    logic [7:0]       shiftReg, shiftNxt;
    logic [7:0]       dataNxt;
    logic             rdyNxt, errNxt;
    logic             rxMeta, rxSync;

    // Synchronizer flops reset to the idle line level so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shiftReg     <= '0;
            rx_data      <= 8'h00;
            rx_data_rdy  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= stateNxt;
            cnt          <= cntNxt;
            idx          <= idxNxt;
            shiftReg     <= shiftNxt;
            rx_data      <= dataNxt;
            rx_data_rdy  <= rdyNxt;
            rx_frame_err <= errNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        idxNxt   = idx;
        shiftNxt = shiftReg;
        dataNxt  = rx_data;
        rdyNxt   = 1'b0;
        errNxt   = 1'b0;
        case (state)
            IDLE: begin
                if (!rxSync) begin
                    stateNxt = START;
                    cntNxt   = '0;
                end
            end
            START: begin
                // Half a bit in: a line that has gone high again was only a glitch.
                if (cnt == HALF_CNT) begin
                    cntNxt   = '0;
                    idxNxt   = '0;
                    stateNxt = rxSync ? IDLE : DATA;
                end else begin
                    cntNxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == FULL_CNT) begin
                    cntNxt   = '0;
                    shiftNxt = {rxSync, shiftReg[7:1]};
                    if (idx == 3'd7) begin
                        stateNxt = STOP;
                    end else begin
                        idxNxt = idx + 3'd1;
                    end
                end else begin
                    cntNxt = cnt + 1'b1;
                end
            end
            STOP: begin
                // Leaving at stop-bit centre lets a start bit right behind it be caught.
                if (cnt == FULL_CNT) begin
                    cntNxt = '0;
                    if (rxSync) begin
                        dataNxt  = shiftReg;
                        rdyNxt   = 1'b1;
                        stateNxt = IDLE;
                    end else begin
                        errNxt   = 1'b1;
                        stateNxt = BREAK;
                    end
                end else begin
                    cntNxt = cnt + 1'b1;
                end
            end
            BREAK: begin
                if (rxSync) begin
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end
endmodule
